// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that time-shares one uart_tx serializer between NUM_REQ byte producers,
// optionally prefixing each data byte with a {4'hA, id} source-tag header.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_EN  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] active_id,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Handshake with uart_tx: tx_start is a one-cycle pulse qualifying tx_data; the serializer
   // owns the line from the cycle after tx_start until it drops tx_busy.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HDR_START = 3'd1,
      HDR_WAIT  = 3'd2,
      DAT_START = 3'd3,
      DAT_WAIT  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [7:0]           data_q, data_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 busy_q, busy_d;

   logic [7:0]           req_bytes [NUM_REQ];
   logic                 win_found;
   logic [ID_W-1:0]      win_id;
   logic [ID_W-1:0]      cand;
   int                   cand_int;
   logic [7:0]           win_hdr;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[8*g +: 8];
   end

   // First set request searched upward from ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      cand_int  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_int = int'(ptr_q) + i;
         if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
         cand = ID_W'(cand_int);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign win_hdr = {4'hA, 4'(win_id)};

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      data_d     = data_q;
      gnt_d      = '0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            if (!tx_busy && win_found) begin
               id_d       = win_id;
               data_d     = req_bytes[win_id];
               ptr_d      = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
               gnt_d      = NUM_REQ'(1) << win_id;
               tx_start_d = 1'b1;
               if (TAG_EN != 0) begin
                  state_d   = HDR_START;
                  tx_data_d = win_hdr;
               end else begin
                  state_d   = DAT_START;
                  tx_data_d = req_bytes[win_id];
               end
            end
         end
         HDR_START: state_d = HDR_WAIT;
         HDR_WAIT: begin
            // A serializer that never raised tx_busy still lets the frame proceed.
            if (!tx_busy) begin
               state_d    = DAT_START;
               tx_start_d = 1'b1;
               tx_data_d  = data_q;
            end
         end
         DAT_START: state_d = DAT_WAIT;
         DAT_WAIT: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         data_q     <= 8'h00;
         gnt_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         data_q     <= data_d;
         gnt_q      <= gnt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign active_id = id_q;
   assign busy      = busy_q;

endmodule
